// File: rtl/iob_ram_rd_stream.sv
// Streams a block of words out of a 1-cycle-latency RAM read port onto a
// valid/ready stream. A 2-entry skid FIFO absorbs the read latency so the
// stream can run at one beat per cycle while still honouring back-pressure.
module iob_ram_rd_stream #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              r_en_o,
    output logic [ADDR_W-1:0] r_addr_o,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;      // reads still to issue
    logic                inflight_q;        // read issued last cycle
    logic                done_q, done_d;
    logic [DATA_W-1:0]   fifo_q [2];
    logic                rd_ptr_q, wr_ptr_q;
    logic [1:0]          occ_q;

    logic                pop, push, room, issue;

    assign pop  = (occ_q != 2'd0) && m_ready_i;
    assign push = inflight_q;
    // Issue only if the word will have a FIFO slot when it lands:
    // occupancy + inflight - pop < 2, rearranged to avoid underflow.
    assign room  = ({1'b0, occ_q} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});
    assign issue = (state_q == READ) && (rem_q != '0) && room;

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign r_en_o    = issue;
    assign r_addr_o  = addr_q;
    assign m_valid_o = (occ_q != 2'd0);
    assign m_data_o  = fifo_q[rd_ptr_q];

    // Next-state: latch the job, count down issued reads, finish on last pop.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = base_addr_i;
                        rem_d   = len_i;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - (ADDR_W+1)'(1);
                    if (rem_q == (ADDR_W+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing left in flight and the only buffered word leaves now.
                if (pop && (occ_q == 2'd1) && !inflight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
            done_q     <= done_d;
        end
    end

    // Skid FIFO: capture returning read data, release on stream handshake.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= r_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_iob_ram_rd_stream.sv
// Bench for iob_ram_rd_stream: directed vector table, reset/abort sequence,
// and randomized transfers scored against a simple address-order model.
module tb_iob_ram_rd_stream;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, r_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data = '0;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready = 1'b0;

    iob_ram_rd_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .arst_i(arst), .start_i(start), .base_addr_i(base_addr),
        .len_i(len), .busy_o(busy), .done_o(done), .r_en_o(r_en),
        .r_addr_o(r_addr), .r_data_i(r_data), .m_valid_o(m_valid),
        .m_data_o(m_data), .m_ready_i(m_ready)
    );

    always #5 clk = ~clk;

    // RAM model: data = addr[7:0] ^ 0x5A, one cycle after the read enable.
    initial forever begin
        @(posedge clk);
        if (r_en) r_data <= r_addr[7:0] ^ 8'h5A;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor / scoreboard state
    bit             mon_en = 0;
    logic [7:0]     exp_q[$];
    int             cur_base, cur_len;
    int             reads, pops, done_cnt, done_cyc;
    int             first_valid_cyc, last_beat_cyc;
    bit             stall_prev;
    logic [7:0]     prev_data;

    initial forever begin
        @(negedge clk);
        if (mon_en && !arst) begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stall_prev) begin
                chk(m_valid == 1'b1, "hold_valid", m_valid, 1);
                chk(m_data == prev_data, "hold_data", m_data, prev_data);
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                pops++;
                last_beat_cyc = cyc;
                if (exp_q.size() == 0) chk(1'b0, "extra_beat", m_data, 0);
                else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    chk(m_data == e, "beat_data", m_data, e);
                end
            end
            if (r_en) begin
                logic [ADDR_W-1:0] ea;
                reads++;
                ea = ADDR_W'((cur_base + reads - 1) % DEPTH);
                chk(reads <= cur_len, "read_count", reads, cur_len);
                chk(r_addr == ea, "r_addr", r_addr, ea);
                chk(busy == 1'b1, "busy_on_read", busy, 1);
                chk(reads - pops <= 2, "outstanding", reads - pops, 2);
            end
        end
    end

    task automatic mon_arm(input int b, input int l);
        cur_base = b; cur_len = l;
        reads = 0; pops = 0; done_cnt = 0; done_cyc = -1;
        first_valid_cyc = -1; last_beat_cyc = -1; stall_prev = 0;
        mon_en = 1;
    endtask

    // mode 0: ready held high; 1: ready low for `stall` cycles from first valid; 2: random ready
    task automatic run_xfer(input int b, input int l, input int mode, input int stall);
        int start_cyc, t, budget;
        mon_arm(b, l);
        @(posedge clk); #1;
        base_addr = ADDR_W'(b);
        len       = (ADDR_W+1)'(l);
        start     = 1'b1;
        m_ready   = (mode == 0);
        @(posedge clk); #1;
        start     = 1'b0;
        start_cyc = cyc;
        budget    = 4 * l + 50;
        for (t = 0; t < budget; t++) begin
            if (done_cnt > 0) break;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (first_valid_cyc >= 0) && (cyc >= first_valid_cyc + stall);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1;
        end
        chk(t < budget, "timeout", t, budget);
        @(negedge clk); #1;
        chk(done == 1'b0, "done_single", done, 0);
        chk(busy == 1'b0, "idle_after", busy, 0);
        chk(done_cnt == 1, "done_count", done_cnt, 1);
        chk(exp_q.size() == 0, "beats_left", exp_q.size(), 0);
        chk(reads == l, "reads_total", reads, l);
        if (l == 0) begin
            chk(done_cyc == start_cyc, "len0_done_time", done_cyc - start_cyc, 0);
            chk(first_valid_cyc < 0, "len0_no_valid", first_valid_cyc, -1);
        end else if (mode == 0) begin
            chk(first_valid_cyc - start_cyc == 2, "first_valid_lat", first_valid_cyc - start_cyc, 2);
            chk(last_beat_cyc - first_valid_cyc == l - 1, "throughput", last_beat_cyc - first_valid_cyc, l - 1);
            chk(done_cyc == last_beat_cyc + 1, "done_time", done_cyc - last_beat_cyc, 1);
        end
        mon_en  = 0;
        m_ready = 1'b0;
    endtask

    typedef struct {
        int         base;
        int         len;
        int         mode;
        int         stall;
        logic [7:0] e [6];
    } vec_t;

    vec_t vt [4];

    initial begin
        vt[0] = '{base: 'h010, len: 4, mode: 0, stall: 0, e: '{8'h4A, 8'h4B, 8'h48, 8'h49, 8'h00, 8'h00}};
        vt[1] = '{base: 'h000, len: 6, mode: 1, stall: 5, e: '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F}};
        vt[2] = '{base: 'h000, len: 0, mode: 0, stall: 0, e: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vt[3] = '{base: 'h3FF, len: 3, mode: 0, stall: 0, e: '{8'hA5, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00}};

        // Reset state
        #2;
        chk({busy, done, r_en, m_valid} == 4'b0, "reset_ctrl", {busy, done, r_en, m_valid}, 0);
        chk(r_addr == '0 && m_data == '0, "reset_data", {r_addr, m_data}, 0);
        @(negedge clk); arst = 1'b0;

        // Directed vector table
        foreach (vt[i]) begin
            exp_q.delete();
            for (int k = 0; k < vt[i].len; k++) exp_q.push_back(vt[i].e[k]);
            run_xfer(vt[i].base, vt[i].len, vt[i].mode, vt[i].stall);
        end

        // Restart while busy is ignored; reset mid-transfer clears everything
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(8'(('h100 + k) & 8'hFF) ^ 8'h5A);
        mon_arm('h100, 8);
        @(posedge clk); #1;
        base_addr = ADDR_W'('h100); len = (ADDR_W+1)'(8); start = 1'b1; m_ready = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        base_addr = ADDR_W'('h200); len = (ADDR_W+1)'(5); start = 1'b1;
        @(posedge clk); #1; start = 1'b0; m_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        m_ready = 1'b0;
        @(negedge clk);
        chk(busy == 1'b1, "busy_mid", busy, 1);
        chk(pops == 2 && exp_q.size() == 6, "restart_ignored", pops, 2);
        #2 arst = 1'b1;
        #1;
        mon_en = 0;
        chk({busy, done, r_en, m_valid} == 4'b0, "abort_ctrl", {busy, done, r_en, m_valid}, 0);
        chk(r_addr == '0, "abort_addr", r_addr, 0);
        chk(m_data == '0, "abort_data", m_data, 0);
        @(negedge clk); arst = 1'b0;

        exp_q.delete();
        exp_q.push_back(8'h7A); exp_q.push_back(8'h7B);
        run_xfer('h020, 2, 0, 0);

        // Randomized transfers against the address-order model
        for (int n = 0; n < 25; n++) begin
            int b, l;
            b = $urandom_range(0, DEPTH - 1);
            l = (n == 24) ? DEPTH : $urandom_range(0, 12);
            exp_q.delete();
            for (int k = 0; k < l; k++) exp_q.push_back(8'(((b + k) % DEPTH) & 'hFF) ^ 8'h5A);
            run_xfer(b, l, (n % 3 == 0) ? 0 : 2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iob_ram_rd_stream.md
IOB_RAM_RD_STREAM -- requirements
Module: iob_ram_rd_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, RAM read-port data width and stream width.
REQ-002 The block SHALL have parameter ADDR_W, default 10, RAM read-port address width.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all sequential logic is on its rising edge.
REQ-004 The block SHALL have port arst_i, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit, single-cycle transfer request, sampled only in IDLE.
REQ-006 The block SHALL have port base_addr_i, input, ADDR_W bits, first RAM word address, sampled with start_i.
REQ-007 The block SHALL have port len_i, input, ADDR_W+1 bits, word count, range 0..2**ADDR_W, sampled with start_i.
REQ-008 The block SHALL have port busy_o, output, 1 bit, high whenever state is not IDLE.
REQ-009 The block SHALL have port done_o, output, 1 bit, one-cycle completion pulse.
REQ-010 The block SHALL have port r_en_o, output, 1 bit, RAM read enable.
REQ-011 The block SHALL have port r_addr_o, output, ADDR_W bits, RAM read address.
REQ-012 The block SHALL have port r_data_i, input, DATA_W bits, RAM read data, valid the cycle after r_en_o is sampled high (1-cycle latency).
REQ-013 The block SHALL have port m_valid_o, output, 1 bit, stream data valid.
REQ-014 The block SHALL have port m_data_o, output, DATA_W bits, stream data.
REQ-015 The block SHALL have port m_ready_i, input, 1 bit, stream sink ready; a beat transfers on a clock edge where m_valid_o and m_ready_i are both high.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, READ and DRAIN.
REQ-017 In IDLE with start_i=1 and len_i!=0, the block SHALL latch base_addr_i and len_i and go to READ.
REQ-018 In IDLE with start_i=1 and len_i=0, the block SHALL stay in IDLE, pulse done_o in the next cycle, and issue no read.
REQ-019 start_i SHALL be ignored while busy_o=1.
REQ-020 In READ, r_en_o SHALL be high, with r_addr_o equal to the next address, iff issued<len and (occupancy + inflight - pop) < 2, where occupancy is the skid-buffer entry count, inflight is the number of reads issued last cycle (0 or 1), and pop is the same-cycle stream handshake (0 or 1).
REQ-021 The address SHALL increment by 1 per issued read and wrap modulo 2**ADDR_W.
REQ-022 Read data SHALL be captured from r_data_i into a 2-entry FIFO skid buffer on the edge after the issuing edge.
REQ-023 m_valid_o SHALL equal (occupancy != 0), and m_data_o SHALL be the oldest entry.
REQ-024 Stream beats SHALL be delivered in address order with none dropped or duplicated.
REQ-025 m_data_o SHALL remain stable while m_valid_o=1 and m_ready_i=0.
REQ-026 The state SHALL move from READ to DRAIN on the edge where the last read is issued.
REQ-027 The state SHALL move from DRAIN to IDLE on the edge of the last stream handshake, with done_o high for exactly the following cycle.
REQ-028 With m_ready_i held at 1, the block SHALL sustain 1 beat per cycle, with the first m_valid_o two cycles after the start edge.
REQ-029 The RAM port SHALL never be read more than len times per transfer.
REQ-030 r_en_o SHALL be 0 in IDLE and DRAIN.

Reset
REQ-031 On arst_i=1, the block SHALL immediately force IDLE, busy_o=0, done_o=0, r_en_o=0, r_addr_o=0, m_valid_o=0, m_data_o=0, and clear all counters and the buffer, including mid-transfer.
REQ-032 After arst_i deasserts, the block SHALL accept start_i on the first clock edge.

Verification
REQ-033 The bench RAM model SHALL return r_data_i = r_addr[7:0]^8'h5A, one cycle after r_en_o.
REQ-034 Stimulus base=0x010, len=4, m_ready_i=1 -> beats 0x4A, 0x4B, 0x48, 0x49 on 4 consecutive cycles, then a single done_o pulse.
REQ-035 Stimulus base=0x000, len=6 with m_ready_i=0 for 5 cycles after the first valid -> at most 2 reads outstanding, m_data_o held at 0x5A, then all 6 beats in order.
REQ-036 Stimulus len=0 -> done_o pulse the next cycle, r_en_o never high, m_valid_o stays 0.
REQ-037 Stimulus base=0x3FF, len=3 -> r_addr_o sequence 0x3FF, 0x000, 0x001, beats 0xA5, 0x5A, 0x5B.
REQ-038 Stimulus start_i pulsed while busy_o=1, then arst_i asserted mid-transfer -> the second start has no effect; on reset all outputs are 0 immediately; a new transfer base=0x020, len=2 then yields 0x7A, 0x7B.
